// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, credit-limited in-order memory requests, instruction buffer,
// redirect flush with in-flight drop, and WFI sleep. Optional bubble counter under `FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_req_addr,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    input  logic        wfi_req,
    input  logic        irq_pending,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [6:0]  id_op,
    output logic [2:0]  id_funct3,
    output logic [11:0] id_funct12
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_SLEEP = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_pc;
    logic [31:0]     r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]     r_fifo_inst [FIFO_DEPTH];

    logic            w_credit_ok;
    logic            w_req_valid;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_id_valid;

    // Credit covers both words in flight and words already buffered, so a push can never find the FIFO full.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_W;

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req_valid = !redirect_valid && w_credit_ok;
                if (!redirect_valid && wfi_req) begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (redirect_valid || irq_pending) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    assign im_req_valid = rst_n && w_req_valid;
    assign im_req_addr  = r_pc;
    assign w_fire       = im_req_valid && im_req_ready;
    assign w_push       = im_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign w_id_valid   = rst_n && (r_count != '0);
    assign w_pop        = w_id_valid && !id_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(im_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path; the response arriving now is already dropped.
                r_pc       <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_drop_cnt <= r_outstanding - CW'(im_rsp_valid);
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (im_rsp_valid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wptr   <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_rsp_pc;
            r_fifo_inst[r_wptr] <= im_rsp_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && (r_count == FULL_CNT)))
            else $fatal(1, "fetch_stage: instruction buffer push while full");
        end
    end
`endif

    assign id_valid   = w_id_valid;
    assign id_pc      = w_id_valid ? r_fifo_pc[r_rptr] : 32'h0;
    assign id_inst    = w_id_valid ? r_fifo_inst[r_rptr] : NOP;
    assign id_op      = id_inst[6:0];
    assign id_funct3  = id_inst[14:12];
    assign id_funct12 = id_inst[31:20];

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_bubble_cnt <= '0;
        end else if ((r_state == ST_FETCH) && !w_id_valid && (r_perf_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-configurable memory model plus a scoreboard of expected
// decode entries, checked every cycle with immediate assertions.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        wfi_req;
    logic        irq_pending;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [6:0]  id_op;
    logic [2:0]  id_funct3;
    logic [11:0] id_funct12;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
`endif

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_req_valid   (im_req_valid),
        .im_req_ready   (im_req_ready),
        .im_req_addr    (im_req_addr),
        .im_rsp_valid   (im_rsp_valid),
        .im_rsp_data    (im_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .wfi_req        (wfi_req),
        .irq_pending    (irq_pending),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_op          (id_op),
        .id_funct3      (id_funct3),
        .id_funct12     (id_funct12)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rsp_hold = 1'b0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    bit          mq_live[$];
    ent_t        exp_q[$];
    logic [31:0] exp_pc = 32'h0;
    bit          sleep_m = 1'b0;
    logic [31:0] exp_perf = 32'h0;
    bit          seen_rst = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0C3A_5F21;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present memory response, sample outputs, then update the reference model at the edge.
    task automatic step();
        int   li;
        int   buffered;
        bit   exp_rv;
        bit   exp_idv;
        bit   fire;
        bit   rsp;
        ent_t e;
        im_rsp_valid = (mq_addr.size() > 0) && (mq_due[0] <= cyc) && !rsp_hold;
        im_rsp_data  = im_rsp_valid ? mem_word(mq_addr[0]) : 32'hDEAD_BEEF;
        #1;
        li = 0;
        foreach (mq_live[i]) if (mq_live[i]) li++;
        buffered = exp_q.size() - li;
        exp_rv  = rst_n && !sleep_m && !redirect_valid && ((mq_addr.size() + buffered) < 2);
        exp_idv = rst_n && (buffered > 0);
        chk("req_valid", {31'b0, im_req_valid}, {31'b0, exp_rv});
        if (exp_rv && im_req_valid) chk("req_addr", im_req_addr, exp_pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, exp_idv});
        if (exp_idv) begin
            e = exp_q[0];
            chk("id_pc", id_pc, e.pc);
            chk("id_inst", id_inst, e.inst);
            chk("id_fields", {10'b0, id_op, id_funct3, id_funct12},
                {10'b0, e.inst[6:0], e.inst[14:12], e.inst[31:20]});
        end else begin
            chk("id_inst_nop", id_inst, NOP);
        end
`ifdef FETCH_PERF_EN
        if (seen_rst) chk("perf_bubble", perf_bubble_cnt, exp_perf);
`endif
        fire = im_req_valid && im_req_ready;
        rsp  = im_rsp_valid;
        @(posedge clk);
        if (!rst_n) begin
            exp_pc = 32'h0;
            sleep_m = 1'b0;
            exp_perf = 32'h0;
            seen_rst = 1'b1;
            exp_q.delete();
            mq_addr.delete();
            mq_due.delete();
            mq_live.delete();
        end else begin
            if (!sleep_m && !exp_idv) exp_perf = exp_perf + 32'd1;
            if (rsp) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
                void'(mq_live.pop_front());
            end
            if (redirect_valid) begin
                exp_q.delete();
                foreach (mq_live[i]) mq_live[i] = 1'b0;
                exp_pc  = redirect_pc;
                sleep_m = 1'b0;
            end else begin
                if (exp_idv && !id_stall) void'(exp_q.pop_front());
                if (!sleep_m && wfi_req) sleep_m = 1'b1;
                else if (sleep_m && irq_pending) sleep_m = 1'b0;
            end
            if (fire) begin
                mq_addr.push_back(im_req_addr);
                mq_due.push_back(cyc + lat);
                mq_live.push_back(!redirect_valid);
                if (!redirect_valid) begin
                    exp_q.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        im_req_ready   = 1'b1;
        im_rsp_valid   = 1'b0;
        im_rsp_data    = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_stall       = 1'b0;
        wfi_req        = 1'b0;
        irq_pending    = 1'b0;

        // Reset
        repeat (3) step();
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC with single-cycle memory
        repeat (10) step();

        // Decode stall fills the buffer and throttles requests
        id_stall = 1'b1;
        repeat (5) step();
        id_stall = 1'b0;
        repeat (6) step();

        // Redirect with two requests in flight
        lat = 3;
        redirect_to(32'h0000_0040);
        repeat (2) step();
        redirect_to(32'h0000_0100);
        repeat (10) step();
        lat = 1;
        repeat (6) step();

        // WFI sleep and interrupt wake
        wfi_req = 1'b1;
        step();
        wfi_req = 1'b0;
        repeat (10) step();
        irq_pending = 1'b1;
        step();
        irq_pending = 1'b0;
        repeat (6) step();

        // Redirect wakes sleep; WFI together with redirect stays in fetch
        wfi_req = 1'b1;
        step();
        wfi_req = 1'b0;
        repeat (3) step();
        redirect_to(32'h0000_0200);
        repeat (4) step();
        wfi_req = 1'b1;
        redirect_to(32'h0000_0300);
        wfi_req = 1'b0;
        repeat (5) step();

        // Memory back-pressure holds the request
        id_stall = 1'b1;
        step();
        id_stall = 1'b0;
        im_req_ready = 1'b0;
        repeat (3) step();
        im_req_ready = 1'b1;
        repeat (5) step();

        // Mixed back-pressure, stalls and held responses
        for (int i = 0; i < 40; i++) begin
            im_req_ready = ($urandom_range(0, 3) != 0);
            id_stall     = ($urandom_range(0, 3) == 0);
            rsp_hold     = ($urandom_range(0, 4) == 0);
            lat          = $urandom_range(1, 3);
            step();
        end
        im_req_ready = 1'b1;
        id_stall     = 1'b0;
        rsp_hold     = 1'b0;
        lat          = 1;
        repeat (4) step();

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFF8);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
